apb_slave_ctrl: RTL
===================

Name: apb_slave_ctrl

Overview:
Parametrised APB4 slave front end for the timer register file. It is the successor to the fixed single-cycle handshake block.
- Captures address, write data and strobes in the setup phase.
- Inserts a configurable number of wait states.
- Decodes a register index, issues single-cycle write/read strobes to the register bank and returns read data with PREADY.
- Sits between the APB interconnect and the timer register bank.

Parameters:
ADDR_W, 12, APB address width in bits
DATA_W, 32, APB data width; must be 8, 16 or 32
NUM_REGS, 16, number of word registers mapped from address 0; power of two, at least 2
WAIT_STATES, 0, access-phase wait cycles inserted before PREADY (0..15)

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst  input  1  reset, asynchronous, active-high
tim_psel  input  1  APB select
tim_penable  input  1  APB enable (access phase)
tim_pwrite  input  1  1 = write, 0 = read
tim_paddr  input  ADDR_W  byte address
tim_pwdata  input  DATA_W  write data
tim_pstrb  input  DATA_W/8  write byte strobes
tim_prdata  output  DATA_W  read data
tim_pready  output  1  transfer complete
tim_pslverr  output  1  error response
reg_idx  output  clog2(NUM_REGS)  latched word index = paddr / (DATA_W/8)
reg_wdata  output  DATA_W  latched write data
reg_wstrb  output  DATA_W/8  latched strobes
reg_rdata  input  DATA_W  combinational read data for reg_idx
wr_en  output  1  one-cycle write strobe
rd_en  output  1  one-cycle read strobe

Behaviour:
- One clock; reset is asynchronous and active-high. sys_rst forces state IDLE, counter 0, and the latched idx/wdata/wstrb/write/err to 0.
- All outputs are 0 during reset and after release until a transfer occurs.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when psel=1 and penable=0 (setup), latch paddr, pwdata, pstrb, pwrite and the error flag. Go to DONE if WAIT_STATES=0, else go to WAIT with cnt=1.
  - WAIT: cnt increments each cycle. When cnt==WAIT_STATES, go to DONE.
  - DONE: go to IDLE.
- Outputs in DONE:
  - tim_pready = (state==DONE) & psel & penable (combinational from registered state). PREADY is never asserted outside DONE.
  - wr_en = pready & write & ~err; rd_en = pready & ~write & ~err. Each is exactly one cycle per transfer.
  - tim_prdata = reg_rdata when rd_en=1, else 0.
  - tim_pslverr = pready & err.
- Latency: setup at cycle T0 gives PREADY at T0+1+WAIT_STATES. A zero-wait transfer completes in 2 cycles.
- Back-to-back: a setup phase in the cycle after DONE is captured from IDLE with no lost cycle beyond the APB minimum.
- Abort: if psel falls in WAIT or DONE, return to IDLE. No wr_en/rd_en/pready is issued and the latched data is discarded.
- Setup with penable already high in IDLE (protocol violation) is ignored; remain in IDLE.
- Reads ignore pstrb. Writes with pstrb=0 still pulse wr_en; the bank masks the data with reg_wstrb.
- Reset asserted mid-transfer: immediate IDLE, and no strobe is issued after release.

Optional Feature:
APB_SLVERR_EN defined:
- err = (paddr >= NUM_REGS*DATA_W/8) | (paddr[log2(DATA_W/8)-1:0] != 0).
- An erroring transfer completes with pready=1, pslverr=1, prdata=0 and no wr_en/rd_en.

APB_SLVERR_EN undefined:
- err is tied 0 and tim_pslverr is constant 0.
- The index uses truncated address bits, so out-of-range addresses alias into the register space.

Decomposition:
- Shared package tim_apb_pkg: FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), a byte-lane count constant/function, and a clog2 function.
- One sub-module, apb_addr_dec: combinational paddr -> reg_idx plus error flag, instantiated once and sampled in setup.

Test Plan:
- WAIT_STATES=0, write 0xDEADBEEF to 0x008, pstrb=0xF -> pready and wr_en high in cycle T1 only; reg_idx=2, reg_wdata=0xDEADBEEF.
- WAIT_STATES=3, read 0x004 with reg_rdata=0x1234 -> pready in T4 only; rd_en in T4 only; prdata=0x1234 in T4, 0 otherwise.
- Back-to-back: write 0x000 then read 0x03C, zero wait -> two transfers each of 2 cycles; idx 0 then 15; exactly one wr_en and one rd_en.
- APB_SLVERR_EN, NUM_REGS=16: write to 0x040 and to 0x002 -> pready=1 and pslverr=1, wr_en stays 0. Without the macro, 0x040 writes idx 0 and pslverr=0.
- WAIT_STATES=3: psel dropped in T2 -> state returns to IDLE; pready, wr_en and rd_en never assert.
- sys_rst pulsed in T2 of a wait-state transfer -> all outputs 0 immediately; next setup after release completes normally.

Source files
------------

// File: rtl/tim_apb_pkg.sv
// rtl/tim_apb_pkg.sv - shared FSM encoding and sizing helpers for the timer APB slave
package tim_apb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_slave_ctrl_if.sv
// rtl/apb_slave_ctrl_if.sv - APB4 bus bundle between interconnect (master) and timer slave
interface apb_slave_ctrl_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic                  tim_psel;
   logic                  tim_penable;
   logic                  tim_pwrite;
   logic [ADDR_W-1:0]     tim_paddr;
   logic [DATA_W-1:0]     tim_pwdata;
   logic [DATA_W/8-1:0]   tim_pstrb;
   logic [DATA_W-1:0]     tim_prdata;
   logic                  tim_pready;
   logic                  tim_pslverr;

   modport master (
      output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
      input  tim_prdata, tim_pready, tim_pslverr
   );

   modport slave (
      input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
      output tim_prdata, tim_pready, tim_pslverr
   );
endinterface

// File: rtl/apb_addr_dec.sv
// rtl/apb_addr_dec.sv - byte address to word index decode; APB_SLVERR_EN adds range/alignment error
module apb_addr_dec
   import tim_apb_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic [ADDR_W-1:0]            paddr_i,
   output logic [clog2(NUM_REGS)-1:0]   idx_o,
   output logic                         err_o
);
   localparam int LANES  = byte_lanes(DATA_W);
   localparam int LANE_B = clog2(LANES);
   localparam int IDX_W  = clog2(NUM_REGS);

   logic [ADDR_W-1:0] word_addr;
   logic              unused_hi;

   // Upper word bits are dropped, so out-of-range addresses alias unless flagged below
   assign word_addr = paddr_i >> LANE_B;
   assign idx_o     = word_addr[IDX_W-1:0];
   assign unused_hi = ^word_addr;

`ifdef APB_SLVERR_EN
   localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W+1)'(NUM_REGS * LANES);
   localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);

   assign err_o = ({1'b0, paddr_i} >= LIMIT) | ((paddr_i & LANE_MASK) != '0);
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: rtl/apb_slave_ctrl.sv
// rtl/apb_slave_ctrl.sv - APB4 slave front end with wait states for the timer register bank
// Error responses are produced only when APB_SLVERR_EN is defined.
module apb_slave_ctrl
   import tim_apb_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   apb_slave_ctrl_if.slave               apb,
   output logic [clog2(NUM_REGS)-1:0]    reg_idx,
   output logic [DATA_W-1:0]             reg_wdata,
   output logic [DATA_W/8-1:0]           reg_wstrb,
   input  logic [DATA_W-1:0]             reg_rdata,
   output logic                          wr_en,
   output logic                          rd_en
);
   localparam int IDX_W = clog2(NUM_REGS);

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [DATA_W/8-1:0]  wstrb_q, wstrb_d;
   logic                 write_q, write_d;
   logic                 err_q, err_d;

   logic [IDX_W-1:0]     dec_idx;
   logic                 dec_err;
   logic                 pready;

   apb_addr_dec #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .paddr_i (apb.tim_paddr),
      .idx_o   (dec_idx),
      .err_o   (dec_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      write_d = write_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            // A setup phase with penable already high is a protocol violation and is ignored
            if (apb.tim_psel && !apb.tim_penable) begin
               idx_d   = dec_idx;
               wdata_d = apb.tim_pwdata;
               wstrb_d = apb.tim_pstrb;
               write_d = apb.tim_pwrite;
               err_d   = dec_err;
               cnt_d   = 4'd1;
               state_d = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!apb.tim_psel)                  state_d = ST_IDLE;
            else if (cnt_q == 4'(WAIT_STATES))  state_d = ST_DONE;
            else                                cnt_d   = cnt_q + 4'd1;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         write_q <= write_d;
         err_q   <= err_d;
      end
   end

   // Dropping psel in DONE suppresses pready and both strobes for that transfer
   assign pready          = (state_q == ST_DONE) & apb.tim_psel & apb.tim_penable;
   assign wr_en           = pready & write_q & ~err_q;
   assign rd_en           = pready & ~write_q & ~err_q;
   assign apb.tim_pready  = pready;
   assign apb.tim_pslverr = pready & err_q;
   assign apb.tim_prdata  = rd_en ? reg_rdata : '0;

   assign reg_idx   = idx_q;
   assign reg_wdata = wdata_q;
   assign reg_wstrb = wstrb_q;

endmodule
